rr_arbiter4: RTL

Four-requester round-robin arbiter for a single shared resource.
- Produces a registered one-hot grant `gnt[3:0]` and its binary index `gnt_idx[1:0]`.
- Sits between requesting agents and the shared resource. The resource's select decode uses `gnt_idx`.
- An owner keeps the grant for as long as it holds its request. Optionally, a hold limit forces rotation.

---
 rtl/rr_arbiter4.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-requester round-robin arbiter with registered one-hot
//               grant, binary grant index and valid flag. An owner keeps the
//               grant while it holds its request; on release the next
//               requester in round-robin order takes over with no bubble.
//               Optional hold limit enabled by defining RR_ARB_TIMEOUT_EN:
//               after MAX_HOLD consecutive cycles the owner is rotated out
//               if anyone else is waiting, with a one-cycle timeout pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // Reject configurations where the hold counter cannot reach its limit.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 15) || (MAX_HOLD >= (1 << CNT_W))) begin : g_bad_cfg
        $error("rr_arbiter4: illegal MAX_HOLD/CNT_W combination");
    end

    logic [0:0] r_state_q,   w_state_d;
    logic [3:0] r_gnt_q,     w_gnt_d;
    logic [1:0] r_idx_q,     w_idx_d;
    logic       r_valid_q,   w_valid_d;
    logic       r_timeout_q, w_timeout_d;
    logic [1:0] r_ptr_q,     w_ptr_d;

    logic [3:0] w_req_rot;
    logic [1:0] w_off;
    logic [1:0] w_win;
    logic [3:0] w_win_oh;
    logic       w_any_req;
    logic       w_owner_req;
    logic       w_others;
    logic       w_at_limit;
    logic       w_rotate;
    logic       w_hold;
    logic       w_take_new;

    assign w_any_req   = |req;
    assign w_owner_req = req[r_idx_q];
    assign w_others    = |(req & ~r_gnt_q);

    // Round-robin search: rotate req so the pointer lands on bit 0, then
    // pick the lowest set bit and translate back to an absolute index.
    always_comb begin
        w_req_rot = '0;
        for (int i = 0; i < 4; i++) begin
            w_req_rot[i] = req[r_ptr_q + 2'(i)];
        end
        if (w_req_rot[0])      w_off = 2'd0;
        else if (w_req_rot[1]) w_off = 2'd1;
        else if (w_req_rot[2]) w_off = 2'd2;
        else                   w_off = 2'd3;
    end

    assign w_win    = r_ptr_q + w_off;
    assign w_win_oh = 4'b0001 << w_win;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;

    assign w_at_limit = (r_cnt_q == C_CNT_MAX);

    // Hold counter: counts cycles of continued ownership, saturating at the limit.
    always_comb begin
        w_cnt_d = '0;
        if (w_hold) begin
            w_cnt_d = w_at_limit ? r_cnt_q : (r_cnt_q + CNT_W'(1));
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end
`else
    assign w_at_limit = 1'b0;
`endif

    // Forced rotation only makes sense when somebody else is waiting.
    assign w_rotate = (r_state_q == S_GRANT) && w_owner_req && w_others && w_at_limit;

    // Next-state logic.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  w_state_d = w_any_req ? S_GRANT : S_IDLE;
            S_GRANT: w_state_d = (w_owner_req || w_others) ? S_GRANT : S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: hold, hand over to the search winner, or release.
    always_comb begin
        w_gnt_d     = r_gnt_q;
        w_idx_d     = r_idx_q;
        w_valid_d   = r_valid_q;
        w_ptr_d     = r_ptr_q;
        w_timeout_d = 1'b0;
        w_hold      = 1'b0;
        w_take_new  = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_take_new = w_any_req;
            end
            S_GRANT: begin
                if (w_owner_req && !w_rotate) begin
                    w_hold = 1'b1;
                end else begin
                    // Pointer already sits one past the owner, so the owner
                    // is searched last and cannot win a forced rotation.
                    w_take_new = w_others;
                end
            end
            default: begin
                w_take_new = 1'b0;
            end
        endcase

        if (w_take_new) begin
            w_gnt_d     = w_win_oh;
            w_idx_d     = w_win;
            w_valid_d   = 1'b1;
            w_ptr_d     = w_win + 2'd1;
            w_timeout_d = w_rotate;
        end else if (!w_hold) begin
            w_gnt_d   = 4'b0000;
            w_idx_d   = 2'b00;
            w_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_gnt_q     <= 4'b0000;
            r_idx_q     <= 2'b00;
            r_valid_q   <= 1'b0;
            r_timeout_q <= 1'b0;
            r_ptr_q     <= 2'b00;
        end else begin
            r_state_q   <= w_state_d;
            r_gnt_q     <= w_gnt_d;
            r_idx_q     <= w_idx_d;
            r_valid_q   <= w_valid_d;
            r_timeout_q <= w_timeout_d;
            r_ptr_q     <= w_ptr_d;
        end
    end

    assign gnt       = r_gnt_q;
    assign gnt_idx   = r_idx_q;
    assign gnt_valid = r_valid_q;
    assign timeout   = r_timeout_q;

endmodule
`default_nettype wire
